mesi_isc_breq_arb_n: RTL and testbench

Parametrised N-CPU successor of the broadcast-request FIFO controller in the MESI ISC.
- Issues mbus acknowledges and breq write strobes into N per-CPU breq FIFOs.
- Assigns unique breq IDs and breq types.
- Arbitrates the FIFO heads into the single broad FIFO.
- Arbitration is true round-robin, with an optional quantum-hold mode that lets one CPU drain up to QUANTUM requests back-to-back.

---
 rtl/mesi_isc_pkg.sv | 27 ++
 rtl/mesi_isc_rr_arb.sv | 82 ++++++++
 rtl/mesi_isc_breq_arb_n.sv | 123 ++++++++++++
 tb/tb_mesi_isc_breq_arb_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared MESI ISC encodings and the record carried for one broadcast request.
package mesi_isc_pkg;

    localparam logic [2:0] MESI_ISC_MBUS_CMD_NOP      = 3'd0;
    localparam logic [2:0] MESI_ISC_MBUS_CMD_WR_BROAD = 3'd3;
    localparam logic [2:0] MESI_ISC_MBUS_CMD_RD_BROAD = 3'd4;

    localparam logic [1:0] MESI_ISC_BREQ_TYPE_NOP = 2'd0;
    localparam logic [1:0] MESI_ISC_BREQ_TYPE_WR  = 2'd1;
    localparam logic [1:0] MESI_ISC_BREQ_TYPE_RD  = 2'd2;

    localparam int BREQ_ADDR_WIDTH    = 32;
    localparam int BREQ_TYPE_WIDTH    = 2;
    localparam int BREQ_CPU_ID_WIDTH  = 2;
    localparam int BREQ_ID_WIDTH      = 7;

    // Wide enough for QUANTUM up to 15.
    localparam int ARB_HOLD_CNT_WIDTH = 4;

    typedef struct packed {
        logic [BREQ_ADDR_WIDTH-1:0]   addr;
        logic [BREQ_TYPE_WIDTH-1:0]   breq_type;
        logic [BREQ_CPU_ID_WIDTH-1:0] cpu_id;
        logic [BREQ_ID_WIDTH-1:0]     id;
    } breq_fields_t;

endpackage

// File: rtl/mesi_isc_rr_arb.sv
// Rotating-priority selector with optional quantum hold; owns the priority
// pointer and the consecutive-grant counter.
module mesi_isc_rr_arb
    import mesi_isc_pkg::*;
#(
    parameter int N       = 4,
    parameter int ID_W    = $clog2(N),
    parameter int QUANTUM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic            mode_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] sel_o,
    output logic            valid_o
);

    localparam int HCW  = ARB_HOLD_CNT_WIDTH;
    localparam int HCW1 = HCW + 1;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            grant;
    logic [HCW:0]    hold_cnt_inc;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        sel_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + ID_W'(i);
            if (!found && req_i[idx]) begin
                sel_o = idx;
                found = 1'b1;
            end
        end
    end

    assign valid_o      = |req_i;
    assign grant        = valid_o && en_i;
    assign gnt_o        = grant ? (N'(1) << sel_o) : '0;
    assign hold_cnt_inc = {1'b0, hold_cnt_q} + HCW1'(1);

    always_comb begin
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        if (grant) begin
            if (!mode_i) begin
                ptr_d      = sel_o + ID_W'(1);
                hold_cnt_d = '0;
            end else if ((sel_o == ptr_q) && (hold_cnt_inc < HCW1'(QUANTUM))) begin
                hold_cnt_d = hold_cnt_inc[HCW-1:0];
            end else if ((sel_o != ptr_q) && (QUANTUM > 1)) begin
                // The jumped-to CPU starts its own quantum with this grant.
                ptr_d      = sel_o;
                hold_cnt_d = HCW'(1);
            end else begin
                ptr_d      = sel_o + ID_W'(1);
                hold_cnt_d = '0;
            end
        end
        if (!mode_i) begin
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/mesi_isc_breq_arb_n.sv
// N-CPU breq controller: mbus acks, breq type/ID generation and arbitration
// of the per-CPU breq FIFO heads into the broad FIFO.
module mesi_isc_breq_arb_n
    import mesi_isc_pkg::*;
#(
    parameter int CPU_COUNT        = 4,
    parameter int CPU_ID_WIDTH     = $clog2(CPU_COUNT),
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7,
    parameter int QUANTUM          = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   arb_mode_i,
    input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0]    mbus_cmd_array_i,
    input  logic [CPU_COUNT-1:0]                   fifo_status_empty_array_i,
    input  logic [CPU_COUNT-1:0]                   fifo_status_full_array_i,
    input  logic                                   broad_fifo_status_full_i,
    input  logic [CPU_COUNT*ADDR_WIDTH-1:0]        broad_addr_array_i,
    input  logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0]  broad_type_array_i,
    input  logic [CPU_COUNT*BROAD_ID_WIDTH-1:0]    broad_id_array_i,
    output logic [CPU_COUNT-1:0]                   mbus_ack_array_o,
    output logic [CPU_COUNT-1:0]                   fifo_wr_array_o,
    output logic [CPU_COUNT-1:0]                   fifo_rd_array_o,
    output logic                                   broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]                  broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]            broad_type_o,
    output logic [CPU_ID_WIDTH-1:0]                broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]              broad_id_o,
    output logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0]  breq_type_array_o,
    output logic [CPU_COUNT*CPU_ID_WIDTH-1:0]      breq_cpu_id_array_o,
    output logic [CPU_COUNT*BROAD_ID_WIDTH-1:0]    breq_id_array_o
);

    localparam int ID_BASE_WIDTH = BROAD_ID_WIDTH - CPU_ID_WIDTH;

    logic [CPU_COUNT-1:0]                  mbus_ack_q, mbus_ack_d;
    logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0] breq_type_q, breq_type_d;
    logic [ID_BASE_WIDTH-1:0]              id_base_q, id_base_d;
    logic [CPU_COUNT-1:0]                  cmd_wr_broad, cmd_rd_broad;
    logic [CPU_ID_WIDTH-1:0]               arb_sel;
    logic                                  arb_valid;
    logic                                  arb_en;

    for (genvar g = 0; g < CPU_COUNT; g++) begin : g_cpu
        assign cmd_wr_broad[g] = mbus_cmd_array_i[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH]
                                 == MBUS_CMD_WIDTH'(MESI_ISC_MBUS_CMD_WR_BROAD);
        assign cmd_rd_broad[g] = mbus_cmd_array_i[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH]
                                 == MBUS_CMD_WIDTH'(MESI_ISC_MBUS_CMD_RD_BROAD);
        assign breq_cpu_id_array_o[g*CPU_ID_WIDTH +: CPU_ID_WIDTH]   = CPU_ID_WIDTH'(g);
        assign breq_id_array_o[g*BROAD_ID_WIDTH +: BROAD_ID_WIDTH]   = {id_base_q, CPU_ID_WIDTH'(g)};
    end

    // Ack is a one-cycle pulse, so a held command is acked every other cycle.
    always_comb begin
        mbus_ack_d  = ~mbus_ack_q & (cmd_wr_broad | cmd_rd_broad) & ~fifo_status_full_array_i;
        breq_type_d = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            if (cmd_wr_broad[i]) begin
                breq_type_d[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] =
                    BROAD_TYPE_WIDTH'(MESI_ISC_BREQ_TYPE_WR);
            end else if (cmd_rd_broad[i]) begin
                breq_type_d[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] =
                    BROAD_TYPE_WIDTH'(MESI_ISC_BREQ_TYPE_RD);
            end
        end
        id_base_d = id_base_q;
        if (|mbus_ack_q) begin
            id_base_d = id_base_q + ID_BASE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbus_ack_q  <= '0;
            breq_type_q <= '0;
            id_base_q   <= '0;
        end else begin
            mbus_ack_q  <= mbus_ack_d;
            breq_type_q <= breq_type_d;
            id_base_q   <= id_base_d;
        end
    end

    assign mbus_ack_array_o  = mbus_ack_q;
    assign fifo_wr_array_o   = mbus_ack_q;
    assign breq_type_array_o = breq_type_q;

    // Reset gates the grant so nothing is popped while rst_n is held low.
    assign arb_en = ~broad_fifo_status_full_i & rst_n;

    mesi_isc_rr_arb #(
        .N       (CPU_COUNT),
        .ID_W    (CPU_ID_WIDTH),
        .QUANTUM (QUANTUM)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (~fifo_status_empty_array_i),
        .mode_i  (arb_mode_i),
        .en_i    (arb_en),
        .gnt_o   (fifo_rd_array_o),
        .sel_o   (arb_sel),
        .valid_o (arb_valid)
    );

    assign broad_fifo_wr_o = |fifo_rd_array_o;
    assign broad_cpu_id_o  = arb_sel;

    always_comb begin
        broad_addr_o = '0;
        broad_type_o = '0;
        broad_id_o   = '0;
        if (arb_valid) begin
            broad_addr_o = broad_addr_array_i[arb_sel*ADDR_WIDTH +: ADDR_WIDTH];
            broad_type_o = broad_type_array_i[arb_sel*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
            broad_id_o   = broad_id_array_i[arb_sel*BROAD_ID_WIDTH +: BROAD_ID_WIDTH];
        end
    end

endmodule

// File: tb/tb_mesi_isc_breq_arb_n.sv
// Directed bench for mesi_isc_breq_arb_n: ack/ID sequences, an arbitration
// vector table and a mid-burst reset.
module tb_mesi_isc_breq_arb_n;
    import mesi_isc_pkg::*;

    localparam int N   = 4;
    localparam int CW  = 3;
    localparam int AW  = 32;
    localparam int TW  = 2;
    localparam int IW  = 7;
    localparam int CIW = 2;
    localparam int Q   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            arb_mode;
    logic [N*CW-1:0] mbus_cmd;
    logic [N-1:0]    empty, full;
    logic            bfull;
    logic [N*AW-1:0] addr_arr;
    logic [N*TW-1:0] type_arr;
    logic [N*IW-1:0] id_arr;
    logic [N-1:0]    ack, fifo_wr, fifo_rd;
    logic            broad_wr;
    logic [AW-1:0]   broad_addr;
    logic [TW-1:0]   broad_type;
    logic [CIW-1:0]  broad_cpu_id;
    logic [IW-1:0]   broad_id;
    logic [N*TW-1:0] breq_type_arr;
    logic [N*CIW-1:0] breq_cpu_id_arr;
    logic [N*IW-1:0] breq_id_arr;

    always #5 clk = ~clk;

    mesi_isc_breq_arb_n #(.CPU_COUNT(N), .QUANTUM(Q)) u_dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .arb_mode_i                (arb_mode),
        .mbus_cmd_array_i          (mbus_cmd),
        .fifo_status_empty_array_i (empty),
        .fifo_status_full_array_i  (full),
        .broad_fifo_status_full_i  (bfull),
        .broad_addr_array_i        (addr_arr),
        .broad_type_array_i        (type_arr),
        .broad_id_array_i          (id_arr),
        .mbus_ack_array_o          (ack),
        .fifo_wr_array_o           (fifo_wr),
        .fifo_rd_array_o           (fifo_rd),
        .broad_fifo_wr_o           (broad_wr),
        .broad_addr_o              (broad_addr),
        .broad_type_o              (broad_type),
        .broad_cpu_id_o            (broad_cpu_id),
        .broad_id_o                (broad_id),
        .breq_type_array_o         (breq_type_arr),
        .breq_cpu_id_array_o       (breq_cpu_id_arr),
        .breq_id_array_o           (breq_id_arr)
    );

    typedef struct {
        logic       mode;
        logic [3:0] empty;
        logic       bfull;
        logic [3:0] exp_rd;
        logic [1:0] exp_sel;
        logic [1:0] exp_ptr;
        logic [3:0] exp_hold;
    } vec_t;

    vec_t         vecs[$];
    breq_fields_t head[N];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av(input logic m, input logic [3:0] e, input logic f, input logic [3:0] rd,
                      input int sel, input int p, input int h);
        vec_t v;
        v.mode = m; v.empty = e; v.bfull = f; v.exp_rd = rd;
        v.exp_sel = 2'(sel); v.exp_ptr = 2'(p); v.exp_hold = 4'(h);
        vecs.push_back(v);
    endtask

    task automatic set_cmd(input int cpu, input logic [2:0] cmd);
        mbus_cmd[cpu*CW +: CW] = cmd;
    endtask

    initial begin
        logic [N*IW-1:0] exp_ids;
        logic [3:0]      ack_pat;
        logic [4:0]      base_pat [4];
        logic            m_ack;
        logic [4:0]      m_base;

        rst_n = 1'b0; arb_mode = 1'b0; mbus_cmd = '0; empty = '1; full = '0; bfull = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i].addr      = 32'h1000_0000 * (i + 1) + 32'(i);
            head[i].breq_type = 2'(3 - i);
            head[i].cpu_id    = 2'(i);
            head[i].id        = 7'(i * 9 + 5);
            addr_arr[i*AW +: AW] = head[i].addr;
            type_arr[i*TW +: TW] = head[i].breq_type;
            id_arr[i*IW +: IW]   = head[i].id;
        end

        // Reset state
        tick();
        empty = '0;
        #1;
        chk("rd_in_reset", 64'(fifo_rd), 64'h0);
        chk("bwr_in_reset", 64'(broad_wr), 64'h0);
        empty = '1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_fifo_wr", 64'(fifo_wr), 64'h0);
        chk("rst_rd", 64'(fifo_rd), 64'h0);
        chk("rst_bwr", 64'(broad_wr), 64'h0);
        chk("rst_addr", 64'(broad_addr), 64'h0);
        chk("rst_type", 64'(broad_type), 64'h0);
        chk("rst_bid", 64'(broad_id), 64'h0);
        chk("rst_cpu_id", 64'(broad_cpu_id), 64'h0);
        chk("rst_breq_type", 64'(breq_type_arr), 64'h0);
        chk("rst_breq_cpu_id", 64'(breq_cpu_id_arr), 64'hE4);
        exp_ids = '0;
        for (int i = 0; i < N; i++) exp_ids[i*IW +: IW] = {5'd0, 2'(i)};
        chk("rst_breq_id", 64'(breq_id_arr), 64'(exp_ids));

        // CPU2 holds WR_BROAD: ack 1,0,1,0 and id_base 0,1,1,2
        tick();
        set_cmd(2, MESI_ISC_MBUS_CMD_WR_BROAD);
        ack_pat = 4'b0101;
        base_pat[0] = 5'd0; base_pat[1] = 5'd1; base_pat[2] = 5'd1; base_pat[3] = 5'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("wr_ack%0d", k), 64'(ack), ack_pat[k] ? 64'h4 : 64'h0);
            chk($sformatf("wr_fifo_wr%0d", k), 64'(fifo_wr), ack_pat[k] ? 64'h4 : 64'h0);
            chk($sformatf("wr_type%0d", k), 64'(breq_type_arr[2*TW +: TW]), 64'(MESI_ISC_BREQ_TYPE_WR));
            chk($sformatf("wr_id%0d", k), 64'(breq_id_arr[2*IW +: IW]), 64'({base_pat[k], 2'b10}));
        end

        // Full FIFO blocks the ack, type still follows the command
        set_cmd(2, MESI_ISC_MBUS_CMD_RD_BROAD);
        full = 4'b0100;
        tick();
        chk("full_ack", 64'(ack), 64'h0);
        chk("full_type", 64'(breq_type_arr[2*TW +: TW]), 64'(MESI_ISC_BREQ_TYPE_RD));
        chk("full_id0", 64'(breq_id_arr[0 +: IW]), 64'({5'd2, 2'b00}));

        // Two simultaneous acks advance id_base only once
        full = '0;
        set_cmd(2, MESI_ISC_MBUS_CMD_NOP);
        set_cmd(0, MESI_ISC_MBUS_CMD_RD_BROAD);
        set_cmd(1, MESI_ISC_MBUS_CMD_RD_BROAD);
        tick();
        chk("dual_ack", 64'(ack), 64'h3);
        chk("dual_type", 64'(breq_type_arr), 64'({MESI_ISC_BREQ_TYPE_NOP, MESI_ISC_BREQ_TYPE_NOP,
                                                  MESI_ISC_BREQ_TYPE_RD, MESI_ISC_BREQ_TYPE_RD}));
        mbus_cmd = '0;
        tick();
        chk("dual_ack_off", 64'(ack), 64'h0);
        chk("dual_id1", 64'(breq_id_arr[1*IW +: IW]), 64'({5'd3, 2'b01}));

        // id_base wraps through all-ones back to 0
        set_cmd(0, MESI_ISC_MBUS_CMD_RD_BROAD);
        m_ack = 1'b0; m_base = 5'd3;
        for (int c = 0; c < 64; c++) begin
            tick();
            m_base = m_base + 5'(m_ack);
            m_ack  = ~m_ack;
            chk($sformatf("wrap_ack%0d", c), 64'(ack[0]), 64'(m_ack));
            chk($sformatf("wrap_id%0d", c), 64'(breq_id_arr[0 +: IW]), 64'({m_base, 2'b00}));
        end
        mbus_cmd = '0;
        tick();

        // Arbitration table: mode, empty, bfull, rd, sel, ptr after, hold after
        av(0, 4'h0, 0, 4'b0001, 0, 1, 0);
        av(0, 4'h0, 0, 4'b0010, 1, 2, 0);
        av(0, 4'h0, 0, 4'b0100, 2, 3, 0);
        av(0, 4'h0, 0, 4'b1000, 3, 0, 0);
        av(0, 4'h0, 0, 4'b0001, 0, 1, 0);
        av(0, 4'h0, 0, 4'b0010, 1, 2, 0);
        av(0, 4'h0, 0, 4'b0100, 2, 3, 0);
        av(0, 4'h0, 0, 4'b1000, 3, 0, 0);
        av(0, 4'h5, 0, 4'b0010, 1, 2, 0);
        av(0, 4'h5, 0, 4'b1000, 3, 0, 0);
        av(0, 4'h5, 0, 4'b0010, 1, 2, 0);
        av(0, 4'h5, 0, 4'b1000, 3, 0, 0);
        av(0, 4'h0, 0, 4'b0001, 0, 1, 0);
        av(0, 4'h0, 1, 4'b0000, 1, 1, 0);
        av(0, 4'h0, 1, 4'b0000, 1, 1, 0);
        av(0, 4'h0, 1, 4'b0000, 1, 1, 0);
        av(0, 4'h0, 0, 4'b0010, 1, 2, 0);
        av(0, 4'h0, 0, 4'b0100, 2, 3, 0);
        av(0, 4'h0, 0, 4'b1000, 3, 0, 0);
        av(1, 4'h0, 0, 4'b0001, 0, 0, 1);
        av(1, 4'h0, 0, 4'b0001, 0, 0, 2);
        av(1, 4'h0, 0, 4'b0001, 0, 1, 0);
        av(1, 4'h0, 0, 4'b0010, 1, 1, 1);
        av(1, 4'h0, 0, 4'b0010, 1, 1, 2);
        av(1, 4'h0, 0, 4'b0010, 1, 2, 0);
        av(1, 4'h0, 0, 4'b0100, 2, 2, 1);
        av(1, 4'h0, 1, 4'b0000, 2, 2, 1);
        av(1, 4'h0, 0, 4'b0100, 2, 2, 2);
        av(1, 4'h0, 0, 4'b0100, 2, 3, 0);
        av(1, 4'h0, 0, 4'b1000, 3, 3, 1);
        av(1, 4'h0, 0, 4'b1000, 3, 3, 2);
        av(1, 4'h0, 0, 4'b1000, 3, 0, 0);
        av(1, 4'h0, 0, 4'b0001, 0, 0, 1);
        av(1, 4'h0, 0, 4'b0001, 0, 0, 2);
        av(1, 4'h1, 0, 4'b0010, 1, 1, 1);
        av(1, 4'h1, 0, 4'b0010, 1, 1, 2);
        av(1, 4'h1, 0, 4'b0010, 1, 2, 0);
        av(1, 4'h0, 0, 4'b0100, 2, 2, 1);
        av(0, 4'h0, 0, 4'b0100, 2, 3, 0);
        av(0, 4'hF, 0, 4'b0000, 0, 3, 0);
        av(1, 4'h0, 0, 4'b1000, 3, 3, 1);
        av(0, 4'hF, 0, 4'b0000, 0, 3, 0);
        av(0, 4'h0, 0, 4'b1000, 3, 0, 0);

        foreach (vecs[k]) begin
            arb_mode = vecs[k].mode;
            empty    = vecs[k].empty;
            bfull    = vecs[k].bfull;
            #2;
            chk($sformatf("v%0d_rd", k), 64'(fifo_rd), 64'(vecs[k].exp_rd));
            chk($sformatf("v%0d_bwr", k), 64'(broad_wr), 64'(|vecs[k].exp_rd));
            if (vecs[k].empty != 4'hF) begin
                chk($sformatf("v%0d_cpu", k), 64'(broad_cpu_id), 64'(vecs[k].exp_sel));
                chk($sformatf("v%0d_addr", k), 64'(broad_addr), 64'(head[vecs[k].exp_sel].addr));
                chk($sformatf("v%0d_type", k), 64'(broad_type), 64'(head[vecs[k].exp_sel].breq_type));
                chk($sformatf("v%0d_bid", k), 64'(broad_id), 64'(head[vecs[k].exp_sel].id));
            end else begin
                chk($sformatf("v%0d_addr0", k), 64'(broad_addr), 64'h0);
                chk($sformatf("v%0d_type0", k), 64'(broad_type), 64'h0);
                chk($sformatf("v%0d_bid0", k), 64'(broad_id), 64'h0);
            end
            tick();
            chk($sformatf("v%0d_ptr", k), 64'(u_dut.u_arb.ptr_q), 64'(vecs[k].exp_ptr));
            chk($sformatf("v%0d_hold", k), 64'(u_dut.u_arb.hold_cnt_q), 64'(vecs[k].exp_hold));
        end

        // Reset pulsed mid-burst: ack and ptr clear at once, no grant while low
        arb_mode = 1'b0; empty = '0; bfull = 1'b0;
        set_cmd(2, MESI_ISC_MBUS_CMD_WR_BROAD);
        tick();
        chk("mid_ack_pre", 64'(ack), 64'h4);
        chk("mid_ptr_pre", 64'(u_dut.u_arb.ptr_q), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_ack", 64'(ack), 64'h0);
        chk("mid_ptr", 64'(u_dut.u_arb.ptr_q), 64'h0);
        chk("mid_rd", 64'(fifo_rd), 64'h0);
        chk("mid_bwr", 64'(broad_wr), 64'h0);
        tick();
        chk("mid_rd_held", 64'(fifo_rd), 64'h0);
        chk("mid_ack_held", 64'(ack), 64'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rd_release", 64'(fifo_rd), 64'h1);
        chk("mid_id_release", 64'(breq_id_arr[2*IW +: IW]), 64'({5'd0, 2'b10}));
        mbus_cmd = '0;
        empty = '1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
